// File: rtl/int_seq.sv
// Interrupt/reset sequencer: prioritises RESET > NMI > IRQ (plus software BRK) and steps the
// shared 7-cycle push/vector sequence. Every output except o_inject is a registered copy of state.
module int_seq (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       NMI,
  input  logic       IRQ,
  input  logic       READY,
  input  logic       SYNC,
  input  logic [7:0] i_din,
  input  logic       i_iflag,
  output logic       o_inject,
  output logic       o_seq,
  output logic [2:0] o_step,
  output logic       o_hold_pc,
  output logic       o_rw_inh,
  output logic       o_bflag,
  output logic       o_set_i,
  output logic [7:0] o_vec_lo,
  output logic       o_nmi_ack
);

  // state | meaning: IDLE no sequence | S1 dummy read | S2 push PCH | S3 push PCL
  //                  S4 push P, vector commit | S5 vector low fetch | S6 vector high fetch
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S1     = 3'd1;
  localparam logic [2:0] S2     = 3'd2;
  localparam logic [2:0] S3     = 3'd3;
  localparam logic [2:0] S4     = 3'd4;
  localparam logic [2:0] S5     = 3'd5;
  localparam logic [2:0] S6     = 3'd6;

  localparam logic [1:0] T_RST = 2'd0;
  localparam logic [1:0] T_NMI = 2'd1;
  localparam logic [1:0] T_IRQ = 2'd2;
  localparam logic [1:0] T_BRK = 2'd3;

  localparam logic [7:0] V_NMI = 8'hFA;
  localparam logic [7:0] V_RST = 8'hFC;
  localparam logic [7:0] V_IRQ = 8'hFE;

  logic [2:0] state_q, state_d;
  logic [1:0] type_q, type_d;
  logic [7:0] vec_q, vec_d;
  logic       rst_pend_q, rst_pend_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_smp_q;

  logic       seq_q, seq_d;
  logic       hold_q, hold_d;
  logic       rw_q, rw_d;
  logic       bflag_q, bflag_d;
  logic       seti_q, seti_d;
  logic [7:0] veclo_q, veclo_d;
  logic       ack_q, ack_d;

  logic       nmi_fall;
  logic       irq_take;
  logic       any_pend;
  logic       sync_idle;
  logic       hw_go;
  logic       brk_go;
  logic       commit;
  logic       nmi_commit;

  assign nmi_fall  = nmi_smp_q & ~NMI;
  assign irq_take  = ~IRQ & ~i_iflag;
  assign any_pend  = rst_pend_q | nmi_pend_q | irq_take;
  // Gated by i_rst so o_inject also sits at its reset value while reset is held.
  assign sync_idle = SYNC & READY & (state_q == S_IDLE) & ~i_rst;
  assign hw_go     = sync_idle & any_pend;
  assign brk_go    = sync_idle & ~any_pend & (i_din == 8'h00);

  // A pending NMI at the end of S4 takes over IRQ/BRK vectors; RESET is never hijacked.
  assign commit     = READY & (state_q == S4);
  assign nmi_commit = commit & (type_q != T_RST) & ((type_q == T_NMI) | nmi_pend_q);

  assign o_inject = hw_go;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    vec_d   = vec_q;
    if (READY) begin
      case (state_q)
        S_IDLE: begin
          if (hw_go) begin
            state_d = S1;
            if (rst_pend_q)      type_d = T_RST;
            else if (nmi_pend_q) type_d = T_NMI;
            else                 type_d = T_IRQ;
          end else if (brk_go) begin
            state_d = S1;
            type_d  = T_BRK;
          end
        end
        S6:      state_d = S_IDLE;
        default: state_d = state_q + 3'd1;
      endcase
    end
    if (commit) begin
      if (type_q == T_RST) vec_d = V_RST;
      else if (nmi_commit) vec_d = V_NMI;
      else                 vec_d = V_IRQ;
    end
  end

  // A fresh edge seen on the commit edge itself wins over the clear and stays pending.
  assign rst_pend_d = rst_pend_q & ~(READY & (state_q == S6));
  assign nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_commit);

  always_comb begin
    seq_d   = seq_q;
    hold_d  = hold_q;
    rw_d    = rw_q;
    bflag_d = bflag_q;
    seti_d  = seti_q;
    veclo_d = veclo_q;
    ack_d   = ack_q;
    if (READY) begin
      seq_d   = (state_d != S_IDLE);
      hold_d  = (state_d == S1) & (type_d != T_BRK);
      rw_d    = ((state_d == S2) | (state_d == S3) | (state_d == S4)) & (type_d == T_RST);
      bflag_d = (state_d == S4) & (type_d == T_BRK);
      seti_d  = (state_d == S5);
      ack_d   = nmi_commit;
      if (state_d == S5)      veclo_d = vec_d;
      else if (state_d == S6) veclo_d = vec_d | 8'h01;
      else                    veclo_d = 8'h00;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      type_q     <= T_RST;
      vec_q      <= 8'h00;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_smp_q  <= 1'b1;
      seq_q      <= 1'b0;
      hold_q     <= 1'b0;
      rw_q       <= 1'b0;
      bflag_q    <= 1'b0;
      seti_q     <= 1'b0;
      veclo_q    <= 8'h00;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      vec_q      <= vec_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_smp_q  <= NMI;
      seq_q      <= seq_d;
      hold_q     <= hold_d;
      rw_q       <= rw_d;
      bflag_q    <= bflag_d;
      seti_q     <= seti_d;
      veclo_q    <= veclo_d;
      ack_q      <= ack_d;
    end
  end

  assign o_seq     = seq_q;
  assign o_step    = state_q;
  assign o_hold_pc = hold_q;
  assign o_rw_inh  = rw_q;
  assign o_bflag   = bflag_q;
  assign o_set_i   = seti_q;
  assign o_vec_lo  = veclo_q;
  assign o_nmi_ack = ack_q;

endmodule
